sprite_scheduler: RTL and testbench
===================================

SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters (fixed range 2..4; id width 2).
REQ-002 Parameter: BURST_MAX, 8, max consecutive same-sel issues while another sel is pending.
REQ-003 Parameter: ADDR_W, SPRITE_ADDR_WIDTH, sprite ROM address width.
REQ-004 i_clk  in  1  single clock.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  N_REQ  per-requester lookup request, held until granted.
REQ-007 i_req_sel  in  2*N_REQ  per-requester sprite select (00 dino, 01 dino_duck, 10 cactus, 11 bird).
REQ-008 i_req_addr  in  ADDR_W*N_REQ  per-requester sprite pixel address.
REQ-009 o_gnt  out  N_REQ  one-hot combinational grant; request consumed on the edge where req&gnt.
REQ-010 o_sel  out  2  registered select to sprites block.
REQ-011 o_addr  out  ADDR_W  registered address to sprites block.
REQ-012 i_pixel_color  in  8  colour returned by sprites block.
REQ-013 o_rsp_valid  out  1  response valid.
REQ-014 o_rsp_id  out  2  requester index of response.
REQ-015 o_rsp_color  out  8  response colour (= i_pixel_color when o_rsp_valid).
REQ-016 o_busy  out  1  high when any lookup is in flight.

Function
REQ-017 Grant issued in cycle c SHALL register o_sel/o_addr for cycle c+1; response SHALL appear in cycle c+4 (sprites latency 3).
REQ-018 In-flight tracking SHALL use a 3-stage valid/id pipe v[0..2] (v[0] = cycle of o_addr, v[2] = cycle before response); o_rsp_valid/o_rsp_id SHALL be stage 3 outputs; o_busy = OR of all stages.
REQ-019 At most one grant per cycle; no grant when no request.
REQ-020 o_sel SHALL hold its value while any issued lookup still needs it; a grant whose sel differs from current o_sel SHALL be allowed only when v[0]=0 and v[1]=0 (2-bubble switch penalty).
REQ-021 Same-sel requests SHALL issue back-to-back, one per cycle, no bubbles.
REQ-022 Arbitration: round-robin starting after last granted id; when a switch is blocked (REQ-020), only requesters matching o_sel are eligible.
REQ-023 States: IDLE (no request, pipe empty), STREAM (issuing current sel), DRAIN (issue stopped, awaiting v[0]=v[1]=0 to switch).
REQ-024 IDLE->STREAM on any request (sel may switch immediately if REQ-020 met); STREAM->DRAIN when burst counter reaches BURST_MAX and a differing-sel request is pending, or no matching-sel request exists while a differing one is pending; DRAIN->STREAM when switch allowed, granting round-robin winner among differing-sel requesters; STREAM->IDLE when no requests.
REQ-025 Burst counter SHALL reset to 1 on each sel switch, increment per same-sel grant, saturate at BURST_MAX; it SHALL not stop issuing when no differing-sel request is pending.
REQ-026 o_rsp_color SHALL be i_pixel_color passed through; value undefined-but-stable-by-design when o_rsp_valid=0 (bench ignores).
REQ-027 Request withdrawn before grant SHALL be dropped without side effects; requester's sel/addr changes while ungranted SHALL be honoured at grant time.

Reset
REQ-028 Asserting i_rst_n low SHALL immediately clear o_gnt, v[0..2], o_rsp_valid, o_busy, burst counter; o_sel=00, o_addr=0, round-robin pointer=N_REQ-1 (requester 0 first), state IDLE.
REQ-029 Reset mid-operation SHALL discard all in-flight lookups; no response for them after release.
REQ-030 First grant SHALL be possible in the first cycle after i_rst_n deasserts.

Verification
REQ-031 Req0 only, sel=10, addr=5 at cycle 0 -> gnt0 cycle 0, o_sel=10/o_addr=5 cycle 1, o_rsp_valid id=0 cycle 4.
REQ-032 Req0..3 all sel=00 held -> grants 0,1,2,3,0,... one per cycle, responses in same order 4 cycles later.
REQ-033 Req0 sel=00, req1 sel=11 held -> after BURST_MAX(8) grants to req0, two bubble cycles, then req1 granted with o_sel=11; no response carries wrong sel colour.
REQ-034 Single req0 sel=01 then req1 sel=10 next cycle -> req1 granted cycle 3 (two-cycle drain), o_sel stays 01 through cycle 3.
REQ-035 Reset asserted in cycle 2 with 2 lookups in flight -> o_rsp_valid never asserts for them; all outputs at reset values same cycle.
REQ-036 Requester drops req before grant -> no grant, no response, arbiter pointer unchanged.

Source files
------------

// File: rtl/sprite_scheduler.sv
// Sprite lookup scheduler. Arbitrates requesters onto the shared sprite ROM port.
// Same-sel lookups stream back to back; a sel switch waits for a two-cycle drain.
module sprite_scheduler #(
    parameter int N_REQ     = 4,
    parameter int BURST_MAX = 8,
    parameter int ADDR_W    = 10
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [2*N_REQ-1:0]        i_req_sel,
    input  logic [ADDR_W*N_REQ-1:0]   i_req_addr,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [1:0]                o_sel,
    output logic [ADDR_W-1:0]         o_addr,
    input  logic [7:0]                i_pixel_color,
    output logic                      o_rsp_valid,
    output logic [1:0]                o_rsp_id,
    output logic [7:0]                o_rsp_color,
    output logic                      o_busy
);

    localparam int              BW        = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0]   BURST_TOP = BW'(BURST_MAX);
    localparam logic [BW-1:0]   BURST_ONE = BW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          v_q, v_d;
    logic [2:0][1:0]     id_q, id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [1:0]          rsp_id_q, rsp_id_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic [1:0]          ptr_q, ptr_d;

    logic [N_REQ-1:0]    req_match;
    logic [N_REQ-1:0]    req_diff;
    logic [N_REQ-1:0]    pick_mask;
    logic [N_REQ-1:0]    gnt;
    logic                sw_ok;
    logic                burst_sat;
    logic [1:0]          gnt_id;
    logic [1:0]          gnt_sel;
    logic [ADDR_W-1:0]   gnt_addr;

    // First set bit of mask searching upward from the requester after ptr.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                                 input logic [1:0]       ptr);
        logic [N_REQ-1:0] pick;
        pick = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (pick == '0 && mask[i] && i == (int'(ptr) + k) % N_REQ) begin
                    pick[i] = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    always_comb begin
        req_match = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_match[i] = i_req[i] && (i_req_sel[2*i +: 2] == sel_q);
        end
        req_diff = i_req & ~req_match;
    end

    // The ROM still samples sel while a lookup sits in v[0] or v[1].
    assign sw_ok     = ~v_q[0] & ~v_q[1];
    assign burst_sat = (burst_q >= BURST_TOP);

    always_comb begin
        state_d   = state_q;
        pick_mask = '0;
        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    state_d   = STREAM;
                    pick_mask = sw_ok ? i_req : req_match;
                end
            end
            STREAM: begin
                if (!(|i_req)) begin
                    state_d = IDLE;
                end else if (|req_diff && (burst_sat || !(|req_match))) begin
                    if (sw_ok) begin
                        pick_mask = req_diff;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    pick_mask = sw_ok ? i_req : req_match;
                end
            end
            DRAIN: begin
                if (!(|i_req)) begin
                    state_d = IDLE;
                end else if (!(|req_diff)) begin
                    state_d = STREAM;
                end else if (sw_ok) begin
                    state_d   = STREAM;
                    pick_mask = req_diff;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt = rr_pick(pick_mask, ptr_q);
    end

    always_comb begin
        gnt_id   = '0;
        gnt_sel  = '0;
        gnt_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id   = 2'(i);
                gnt_sel  = i_req_sel[2*i +: 2];
                gnt_addr = i_req_addr[ADDR_W*i +: ADDR_W];
            end
        end

        sel_d   = sel_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        if (|gnt) begin
            sel_d  = gnt_sel;
            addr_d = gnt_addr;
            ptr_d  = gnt_id;
            if (gnt_sel != sel_q || state_q == IDLE) begin
                burst_d = BURST_ONE;
            end else if (!burst_sat) begin
                burst_d = burst_q + BURST_ONE;
            end
        end

        v_d         = {v_q[1:0], |gnt};
        id_d        = {id_q[1], id_q[0], gnt_id};
        rsp_valid_d = v_q[2];
        rsp_id_d    = id_q[2];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            v_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            burst_q     <= '0;
            ptr_q       <= 2'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            v_q         <= v_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            burst_q     <= burst_d;
            ptr_q       <= ptr_d;
        end
    end

    // Grant is combinational, so it must be masked while reset is held.
    assign o_gnt       = i_rst_n ? gnt : '0;
    assign o_sel       = sel_q;
    assign o_addr      = addr_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_color = i_pixel_color;
    assign o_busy      = (|v_q) | rsp_valid_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: a requester model drives held requests,
// expected responses go into a queue that a negedge monitor drains.
module tb_sprite_scheduler;

    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      req = '0;
    logic [7:0]      req_sel = '0;
    logic [4*AW-1:0] req_addr = '0;
    logic [3:0]      o_gnt;
    logic [1:0]      o_sel;
    logic [AW-1:0]   o_addr;
    logic [7:0]      pix = '0;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_color;
    logic            o_busy;

    sprite_scheduler #(.N_REQ(4), .BURST_MAX(8), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_sel(req_sel),
        .i_req_addr(req_addr), .o_gnt(o_gnt), .o_sel(o_sel), .o_addr(o_addr),
        .i_pixel_color(pix), .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
        .o_rsp_color(rsp_color), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] color;
    } exp_t;

    exp_t          expq[$];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    int            rem[4];
    logic [1:0]    rsel[4];
    logic [AW-1:0] raddr[4];
    int            b;

    function automatic logic [7:0] color_of(input logic [1:0] s, input logic [AW-1:0] a);
        return {s, a[5:0]} ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor plus 3-cycle sprite ROM model; the check runs before the ROM pipe advances.
    initial begin
        logic [1:0]    s1, s2, s3;
        logic [AW-1:0] a1, a2, a3;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: id %0d at cycle %0d, no response required", rsp_id, cyc);
                end else begin
                    e = expq.pop_front();
                    check("rsp_id", 32'(rsp_id), e.id);
                    check("rsp_color", 32'(rsp_color), 32'(e.color));
                    check("rsp_cycle", cyc, e.cyc);
                end
            end
            s3 = s2; a3 = a2;
            s2 = s1; a2 = a1;
            s1 = o_sel; a1 = o_addr;
            pix = color_of(s3, a3);
        end
    end

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            req[i]               = (rem[i] > 0);
            req_sel[2*i +: 2]    = rsel[i];
            req_addr[AW*i +: AW] = raddr[i];
        end
    endtask

    task automatic setreq(input int i, input int n, input logic [1:0] s, input logic [AW-1:0] a);
        rem[i]   = n;
        rsel[i]  = s;
        raddr[i] = a;
    endtask

    task automatic expect_rsp(input int c, input int id, input logic [1:0] s, input logic [AW-1:0] a);
        expq.push_back('{c, id, color_of(s, a)});
    endtask

    // One cycle: check grant at negedge, then consume granted requests after the edge.
    task automatic tick(input logic [3:0] eg);
        logic [3:0] g;
        @(negedge clk);
        check("gnt", 32'(o_gnt), 32'(eg));
        g = o_gnt & req;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                rem[i]--;
                raddr[i]++;
            end
        end
        apply();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) setreq(i, 0, 2'b00, '0);
        apply();
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(o_gnt), 0);
        check("rst_sel", 32'(o_sel), 0);
        check("rst_addr", 32'(o_addr), 0);
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(o_busy), 0);
        rst_n = 1'b1;
        b = cyc;
    endtask

    task automatic drain_check(input string name);
        check(name, expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g3 [15];

        // single lookup, first cycle after reset
        do_reset();
        setreq(0, 1, 2'b10, 10'd5);
        apply();
        expect_rsp(b + 4, 0, 2'b10, 10'd5);
        tick(4'b0001);
        check("t1_sel", 32'(o_sel), 2);
        check("t1_addr", 32'(o_addr), 5);
        check("t1_busy", 32'(o_busy), 1);
        repeat (7) tick(4'b0000);
        drain_check("t1_drain");

        // four same-sel requesters, round robin without bubbles
        do_reset();
        for (int i = 0; i < 4; i++) setreq(i, 2, 2'b00, AW'(16 * i));
        apply();
        for (int k = 0; k < 8; k++) expect_rsp(b + 4 + k, k % 4, 2'b00, AW'(16 * (k % 4) + k / 4));
        for (int k = 0; k < 8; k++) tick(4'(1 << (k % 4)));
        repeat (8) tick(4'b0000);
        drain_check("t2_drain");

        // burst limit, two-bubble switch and switch back
        do_reset();
        setreq(0, 10, 2'b00, 10'd0);
        setreq(1, 1, 2'b11, 10'd32);
        apply();
        for (int k = 0; k < 8; k++) expect_rsp(b + 4 + k, 0, 2'b00, AW'(k));
        expect_rsp(b + 14, 1, 2'b11, 10'd32);
        expect_rsp(b + 17, 0, 2'b00, 10'd8);
        expect_rsp(b + 18, 0, 2'b00, 10'd9);
        g3 = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1,
               4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd1, 4'd1};
        for (int k = 0; k < 15; k++) begin
            tick(g3[k]);
            if (k == 8)  check("t3_sel_hold", 32'(o_sel), 0);
            if (k == 10) check("t3_sel_switch", 32'(o_sel), 3);
        end
        repeat (8) tick(4'b0000);
        drain_check("t3_drain");

        // late differing request waits out the drain
        do_reset();
        setreq(0, 1, 2'b01, 10'd7);
        apply();
        expect_rsp(b + 4, 0, 2'b01, 10'd7);
        expect_rsp(b + 7, 1, 2'b10, 10'd9);
        tick(4'b0001);
        setreq(1, 1, 2'b10, 10'd9);
        apply();
        tick(4'b0000);
        tick(4'b0000);
        check("t4_sel_c3", 32'(o_sel), 1);
        tick(4'b0010);
        check("t4_sel_c4", 32'(o_sel), 2);
        repeat (6) tick(4'b0000);
        drain_check("t4_drain");

        // reset with two lookups in flight and one request still pending
        do_reset();
        setreq(0, 1, 2'b01, 10'd2);
        setreq(1, 1, 2'b01, 10'd3);
        setreq(2, 1, 2'b01, 10'd4);
        apply();
        tick(4'b0001);
        tick(4'b0010);
        rst_n = 1'b0;
        #1;
        check("t5_gnt", 32'(o_gnt), 0);
        check("t5_valid", 32'(rsp_valid), 0);
        check("t5_busy", 32'(o_busy), 0);
        check("t5_sel", 32'(o_sel), 0);
        check("t5_addr", 32'(o_addr), 0);
        for (int i = 0; i < 4; i++) rem[i] = 0;
        apply();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) tick(4'b0000);
        drain_check("t5_drain");

        // withdrawn request leaves the round-robin pointer alone
        do_reset();
        setreq(0, 3, 2'b00, 10'd1);
        apply();
        expect_rsp(b + 4, 0, 2'b00, 10'd1);
        expect_rsp(b + 5, 0, 2'b00, 10'd2);
        expect_rsp(b + 6, 0, 2'b00, 10'd3);
        expect_rsp(b + 7, 1, 2'b00, 10'd40);
        expect_rsp(b + 8, 3, 2'b00, 10'd60);
        tick(4'b0001);
        setreq(2, 1, 2'b11, 10'd50);
        apply();
        tick(4'b0001);
        rem[2] = 0;
        apply();
        tick(4'b0001);
        setreq(1, 1, 2'b00, 10'd40);
        setreq(3, 1, 2'b00, 10'd60);
        apply();
        tick(4'b0010);
        tick(4'b1000);
        repeat (8) tick(4'b0000);
        drain_check("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
